cache_control_nway: RTL

//  Parametrised N-way set-associative write-back cache controller; successor of the fixed 2-way controller.

---
 rtl/cache_control_nway.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/cache_control_nway.sv
// cache_control_nway: N-way set-associative write-back cache controller.
// Sequences hit / write-back / line fill and keeps tree pseudo-LRU state per set.
// Optional feature macro: CACHE_PERF_CNT_EN enables the hit/miss/write-back
// performance counters; when undefined they read as zero and have no flops.
module cache_control_nway #(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [$clog2(SETS)-1:0]  set_idx,
  input  logic [WAYS-1:0]          hit_vec,
  input  logic [WAYS-1:0]          valid_vec,
  input  logic [WAYS-1:0]          dirty_vec,
  input  logic                     pmem_resp,
  output logic                     mem_resp,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [WAYS-1:0]          w_data,
  output logic [WAYS-1:0]          w_tag,
  output logic [WAYS-1:0]          w_valid,
  output logic [WAYS-1:0]          w_dirty,
  output logic                     dirty_in,
  output logic                     datain_sel,
  output logic                     pmem_addr_sel,
  output logic [$clog2(WAYS)-1:0]  victim_way,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]         miss_cnt,
  output logic [CNT_W-1:0]         wb_cnt
);

  localparam int WAY_W   = $clog2(WAYS);
  localparam int NODES   = WAYS - 1;
  localparam int NODE_IW = (WAYS > 2) ? $clog2(WAYS - 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_t;

  state_t                        state, state_next;
  logic [SETS-1:0][NODES-1:0]    plru;
  logic [NODES-1:0]              plru_cur, plru_upd;
  logic [WAY_W-1:0]              victim_q;
  logic [WAY_W-1:0]              hit_way, plru_vict, inv_way, victim_sel, hw_shift;
  logic [NODE_IW-1:0]            node_v, node_u;
  logic                          inv_found, victim_dirty, req, hit, b, d;
  logic                          hit_ev, miss_ev;

  assign req      = mem_read | mem_write;
  assign hit      = |hit_vec;
  assign hit_ev   = (state == S_IDLE) && req && hit;
  assign miss_ev  = (state == S_IDLE) && req && !hit;
  assign plru_cur = plru[set_idx];

  // Encode the one-hot hit vector into a way index
  always_comb begin
    hit_way = '0;
    for (int unsigned i = 0; i < WAYS; i++)
      if (hit_vec[i]) hit_way = WAY_W'(i);
  end

  // Walk the PLRU tree from the root to find the pseudo-LRU way (MSB first)
  always_comb begin
    plru_vict = '0;
    node_v    = '0;
    b         = 1'b0;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      b         = plru_cur[node_v];
      plru_vict = WAY_W'({plru_vict, b});
      node_v    = NODE_IW'({node_v, 1'b1}) + NODE_IW'(b);
    end
  end

  // On a hit, make every node on the hit way's path point away from it
  always_comb begin
    plru_upd = plru_cur;
    node_u   = '0;
    hw_shift = hit_way;
    d        = 1'b0;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      d                = hw_shift[WAY_W-1];
      hw_shift         = WAY_W'({hw_shift, 1'b0});
      plru_upd[node_u] = ~d;
      node_u           = NODE_IW'({node_u, 1'b1}) + NODE_IW'(d);
    end
  end

  // Victim: lowest-index invalid way takes priority over the PLRU choice
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned i = 0; i < WAYS; i++)
      if (!valid_vec[i] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(i);
      end
    victim_sel   = inv_found ? inv_way : plru_vict;
    victim_dirty = valid_vec[victim_sel] & dirty_vec[victim_sel];
  end

  // State, PLRU and latched-victim registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      plru     <= '0;
      victim_q <= '0;
    end else begin
      state <= state_next;
      if (hit_ev)  plru[set_idx] <= plru_upd;
      if (miss_ev) victim_q      <= victim_sel;
    end
  end

  assign victim_way = victim_q;

  // Next-state and datapath control decode
  always_comb begin
    state_next    = state;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    w_data        = '0;
    w_tag         = '0;
    w_valid       = '0;
    w_dirty       = '0;
    dirty_in      = 1'b0;
    datain_sel    = 1'b0;
    pmem_addr_sel = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            if (mem_write) begin
              w_data   = hit_vec;
              w_dirty  = hit_vec;
              dirty_in = 1'b1;
            end
          end else begin
            state_next = victim_dirty ? S_WB : S_FILL;
          end
        end
      end
      S_WB: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (pmem_resp) state_next = S_FILL;
      end
      S_FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          w_data     = WAYS'(1) << victim_q;
          w_tag      = WAYS'(1) << victim_q;
          w_valid    = WAYS'(1) << victim_q;
          w_dirty    = WAYS'(1) << victim_q;
          datain_sel = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
  logic             wb_ev;

  assign wb_ev = (state == S_WB) && pmem_resp;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (hit_ev  && hit_cnt_q  != '1) hit_cnt_q  <= hit_cnt_q  + 1'b1;
      if (miss_ev && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      if (wb_ev   && wb_cnt_q   != '1) wb_cnt_q   <= wb_cnt_q   + 1'b1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
  assign wb_cnt   = '0;
`endif

endmodule
